servo_cmd_sequencer: RTL and testbench

//  Upstream command stage for servo_ctrl. Buffers timed position commands (pwm ratio + dwell)
//  in a small FIFO and drives servo_ctrl's pwm_enable, start_pwm_ratio and target_pwm_ratio.

---
 rtl/servo_defs.sv | 20 ++
 rtl/servo_cmd_sequencer_if.sv | 25 ++
 rtl/servo_cmd_fifo.sv | 71 +++++++
 rtl/servo_cmd_sequencer.sv | 163 ++++++++++++++++
 tb/tb_servo_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_defs.sv
// Shared types and widths for the servo command sequencer.
// Command entries carry a pwm ratio and a dwell time in ticks.
package servo_defs;

    localparam int RATIO_W = 8;
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DWELL = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [RATIO_W-1:0] ratio;
        logic [DWELL_W-1:0] dwell;
    } cmd_t;

endpackage

// File: rtl/servo_cmd_sequencer_if.sv
// Valid/ready command push channel into the sequencer.
// The source drives the command fields; the sequencer answers with ready.
interface servo_cmd_sequencer_if;
    import servo_defs::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [RATIO_W-1:0] cmd_ratio;
    logic [DWELL_W-1:0] cmd_dwell;

    modport master (
        output cmd_valid,
        output cmd_ratio,
        output cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ratio,
        input  cmd_dwell,
        output cmd_ready
    );

endinterface

// File: rtl/servo_cmd_fifo.sv
// Synchronous command FIFO with flush; flush wins over push and pop.
// Pointers wrap naturally because the depth is a power of two.
module servo_cmd_fifo
    import servo_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  cmd_t                 din,
    input  logic                 pop,
    input  logic                 flush,
    output cmd_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_q];
    assign count   = cnt_q;

    // Pointer and occupancy next-state, flush empties everything.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Timed position command sequencer feeding servo_ctrl.
// Holds each queued target for its dwell, counted in prescaled ticks.
module servo_cmd_sequencer
    import servo_defs::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 4,
    parameter int ARM_TICKS  = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [RATIO_W-1:0]          home_ratio,
    servo_cmd_sequencer_if.slave        cmd,
    input  logic                        flush,
    output logic                        pwm_enable,
    output logic [RATIO_W-1:0]          start_pwm_ratio,
    output logic [RATIO_W-1:0]          target_pwm_ratio,
    output logic                        step_done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ARM_TICKS + 1);

    seq_state_e         state_q, state_d;
    logic               en_prev_q;
    logic               pwm_q, pwm_d;
    logic [RATIO_W-1:0] start_q, start_d;
    logic [RATIO_W-1:0] target_q, target_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [AW-1:0]      arm_q, arm_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               step_q, step_d;
    logic               tick;
    logic               expire;
    logic               pop;
    logic               full;
    logic               empty;
    cmd_t               head;
    cmd_t               din;

    assign tick   = (presc_q == PW'(TICK_DIV - 1));
    assign expire = (dwell_q == '0) || (tick && dwell_q == DWELL_W'(1));

    assign cmd.cmd_ready = !full && !flush;
    assign din.ratio     = cmd.cmd_ratio;
    assign din.dwell     = cmd.cmd_dwell;

    servo_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd.cmd_valid && cmd.cmd_ready),
        .din   (din),
        .pop   (pop),
        .flush (flush),
        .head  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Sequencer next-state: arming, dwell countdown and pops.
    always_comb begin
        state_d  = state_q;
        pwm_d    = pwm_q;
        start_d  = start_q;
        target_d = target_q;
        dwell_d  = dwell_q;
        arm_d    = arm_q;
        step_d   = 1'b0;
        pop      = 1'b0;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        if (!enable) begin
            state_d  = ST_IDLE;
            pwm_d    = 1'b0;
            target_d = '0;
            dwell_d  = '0;
            arm_d    = '0;
            presc_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!en_prev_q) begin
                        start_d  = home_ratio;
                        target_d = '0;
                        pwm_d    = 1'b1;
                        arm_d    = '0;
                        presc_d  = '0;
                        state_d  = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tick) begin
                        if (arm_q == AW'(ARM_TICKS - 1)) begin
                            if (!empty && !flush) pop = 1'b1;
                            else                  state_d = ST_WAIT;
                        end else begin
                            arm_d = arm_q + AW'(1);
                        end
                    end
                end
                ST_DWELL: begin
                    if (flush) begin
                        state_d = ST_WAIT;
                    end else if (expire) begin
                        step_d  = 1'b1;
                        dwell_d = '0;
                        if (!empty) pop = 1'b1;
                        else        state_d = ST_WAIT;
                    end else if (tick) begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (!empty && !flush) pop = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (pop) begin
                target_d = head.ratio;
                dwell_d  = head.dwell;
                presc_d  = '0;
                state_d  = ST_DWELL;
            end
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            en_prev_q <= 1'b0;
            pwm_q     <= 1'b0;
            start_q   <= '0;
            target_q  <= '0;
            dwell_q   <= '0;
            arm_q     <= '0;
            presc_q   <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= enable;
            pwm_q     <= pwm_d;
            start_q   <= start_d;
            target_q  <= target_d;
            dwell_q   <= dwell_d;
            arm_q     <= arm_d;
            presc_q   <= presc_d;
            step_q    <= step_d;
        end
    end

    assign pwm_enable       = pwm_q;
    assign start_pwm_ratio  = start_q;
    assign target_pwm_ratio = target_q;
    assign step_done        = step_q;
    assign busy             = (state_q == ST_ARM) || (state_q == ST_DWELL);

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Directed bench for servo_cmd_sequencer (TICK_DIV=4, ARM_TICKS=2).
// Expected values are hand-derived cycle counts from the command timing.
module tb_servo_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] home;
    logic       flush;
    logic       pwm_enable;
    logic [7:0] start_r;
    logic [7:0] target_r;
    logic       step_done;
    logic       busy;
    logic [2:0] fifo_count;
    int         errors = 0;
    int         checks = 0;

    servo_cmd_sequencer_if cmd_bus ();

    servo_cmd_sequencer #(
        .TICK_DIV   (4),
        .FIFO_DEPTH (4),
        .ARM_TICKS  (2)
    ) dut (
        .clock            (clk),
        .reset            (rst),
        .enable           (enable),
        .home_ratio       (home),
        .cmd              (cmd_bus.slave),
        .flush            (flush),
        .pwm_enable       (pwm_enable),
        .start_pwm_ratio  (start_r),
        .target_pwm_ratio (target_r),
        .step_done        (step_done),
        .busy             (busy),
        .fifo_count       (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input int d);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_ratio = 8'(r);
        cmd_bus.cmd_dwell = 8'(d);
        step();
        cmd_bus.cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        home = 8'd0;
        flush = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_ratio = 8'd0;
        cmd_bus.cmd_dwell = 8'd0;

        // 1: reset values, then idle hold
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", pwm_enable, 0);
        chk("rst_target", target_r, 0);
        chk("rst_start", start_r, 0);
        chk("rst_ready", cmd_bus.cmd_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_step", step_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_pwm", pwm_enable, 0);
            chk("hold_target", target_r, 0);
            chk("hold_ready", cmd_bus.cmd_ready, 1);
            chk("hold_count", fifo_count, 0);
        end

        // 2: single command through arm and dwell
        push(200, 3);
        chk("t2_count", fifo_count, 1);
        enable = 1'b1;
        home = 8'd100;
        step();
        chk("t2_pwm", pwm_enable, 1);
        chk("t2_start", start_r, 100);
        chk("t2_tgt_arm", target_r, 0);
        chk("t2_busy_arm", busy, 1);
        repeat (7) step();
        chk("t2_tgt_prepop", target_r, 0);
        step();
        chk("t2_tgt_pop", target_r, 200);
        chk("t2_count_pop", fifo_count, 0);
        repeat (11) step();
        chk("t2_step_early", step_done, 0);
        step();
        chk("t2_step", step_done, 1);
        chk("t2_tgt_done", target_r, 200);
        step();
        chk("t2_step_end", step_done, 0);
        chk("t2_busy_wait", busy, 0);
        chk("t2_tgt_wait", target_r, 200);

        // 3: preload while disabled until full
        enable = 1'b0;
        step();
        chk("t3_pwm_off", pwm_enable, 0);
        chk("t3_tgt_off", target_r, 0);
        for (int i = 0; i < 5; i++) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_ratio = 8'(50 + 10 * i);
            cmd_bus.cmd_dwell = (i < 2) ? 8'd0 : ((i == 2) ? 8'd1 : 8'd9);
            #1;
            chk("t3_ready", cmd_bus.cmd_ready, (i < 4) ? 1 : 0);
            step();
        end
        cmd_bus.cmd_valid = 1'b0;
        chk("t3_count", fifo_count, 4);
        chk("t3_ready_full", cmd_bus.cmd_ready, 0);

        // 4: back-to-back zero dwells
        enable = 1'b1;
        home = 8'd10;
        step();
        chk("t4_pwm", pwm_enable, 1);
        chk("t4_start", start_r, 10);
        repeat (8) step();
        chk("t4_tgt50", target_r, 50);
        chk("t4_cnt3", fifo_count, 3);
        chk("t4_step0", step_done, 0);
        step();
        chk("t4_tgt60", target_r, 60);
        chk("t4_step1", step_done, 1);
        chk("t4_cnt2", fifo_count, 2);
        step();
        chk("t4_tgt70", target_r, 70);
        chk("t4_step2", step_done, 1);
        chk("t4_cnt1", fifo_count, 1);
        repeat (3) step();
        chk("t4_tgt70_hold", target_r, 70);
        chk("t4_step_gap", step_done, 0);
        step();
        chk("t4_tgt80", target_r, 80);
        chk("t4_step3", step_done, 1);
        chk("t4_cnt0", fifo_count, 0);

        // 5: flush mid-dwell with a simultaneous push
        repeat (5) step();
        chk("t5_tgt_pre", target_r, 80);
        chk("t5_busy_pre", busy, 1);
        flush = 1'b1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_ratio = 8'd11;
        cmd_bus.cmd_dwell = 8'd11;
        #1;
        chk("t5_ready_flush", cmd_bus.cmd_ready, 0);
        step();
        flush = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        chk("t5_count", fifo_count, 0);
        chk("t5_tgt", target_r, 80);
        chk("t5_busy_wait", busy, 0);
        chk("t5_step", step_done, 0);
        repeat (3) step();
        chk("t5_tgt_hold", target_r, 80);
        chk("t5_count_hold", fifo_count, 0);

        // 6: pop from WAIT, drop enable mid-dwell, re-arm
        push(120, 2);
        chk("t6_cnt_push", fifo_count, 1);
        chk("t6_tgt_wait", target_r, 80);
        step();
        chk("t6_tgt120", target_r, 120);
        chk("t6_busy", busy, 1);
        push(130, 1);
        push(140, 0);
        chk("t6_cnt2", fifo_count, 2);
        enable = 1'b0;
        step();
        chk("t6_pwm_off", pwm_enable, 0);
        chk("t6_tgt_off", target_r, 0);
        chk("t6_busy_off", busy, 0);
        chk("t6_cnt_keep", fifo_count, 2);
        repeat (2) step();
        enable = 1'b1;
        home = 8'd30;
        step();
        chk("t6_pwm_on", pwm_enable, 1);
        chk("t6_start30", start_r, 30);
        chk("t6_tgt_arm", target_r, 0);
        repeat (7) step();
        chk("t6_tgt_prepop", target_r, 0);
        step();
        chk("t6_tgt130", target_r, 130);
        chk("t6_cnt1", fifo_count, 1);
        repeat (3) step();
        chk("t6_tgt130_hold", target_r, 130);
        step();
        chk("t6_tgt140", target_r, 140);
        chk("t6_step_a", step_done, 1);
        chk("t6_cnt0", fifo_count, 0);
        step();
        chk("t6_step_b", step_done, 1);
        chk("t6_busy_wait", busy, 0);
        chk("t6_tgt140_hold", target_r, 140);
        step();
        chk("t6_step_end", step_done, 0);

        // async reset mid-dwell
        push(150, 5);
        step();
        chk("rst2_tgt150", target_r, 150);
        push(160, 5);
        chk("rst2_cnt1", fifo_count, 1);
        step();
        rst = 1'b1;
        #1;
        chk("rst2_pwm", pwm_enable, 0);
        chk("rst2_target", target_r, 0);
        chk("rst2_start", start_r, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_count", fifo_count, 0);
        chk("rst2_ready", cmd_bus.cmd_ready, 1);
        enable = 1'b0;
        step();
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
